maxhpc_fifo_pack: RTL
=====================

Name: maxhpc_fifo_pack

Overview:
Width upsizer that sits directly downstream of a single-clock FIFO's read side (SHOWAHEAD off, fixed read latency). It issues FIFO reads and packs RATIO consecutive DATA_WD words into one wide output word. The packed word is presented on a valid/ready stream. A flush input forces out a partial word, with a lane-keep mask and a last marker.

Parameters:
DATA_WD, 8, width of one FIFO word (one lane)
RATIO, 4, lanes per output word (2..16)
RD_LAT, 2, cycles from FIFO rd to valid q (1 = FIFO output reg off, 2 = on)

Ports:
clock  in  1  single clock, all logic rising-edge
clear  in  1  reset: synchronous, active-high
fifo_rd  out  1  FIFO read strobe
fifo_q  in  DATA_WD  FIFO read data, valid RD_LAT cycles after fifo_rd
fifo_rempty  in  1  FIFO empty flag
flush  in  1  single-cycle pulse: emit current partial word
m_valid  out  1  output word valid
m_ready  in  1  downstream accept
m_data  out  DATA_WD*RATIO  packed word; lane i at bits [i*DATA_WD +: DATA_WD], lane 0 = oldest
m_keep  out  RATIO  lane i holds data
m_last  out  1  word was produced by a flush

Behaviour:
- Reset: clear high at a rising edge sets the following. fill=0, inflight pipe=0, flushing=0. m_valid=0, m_data=0, m_keep=0, m_last=0, fifo_rd=0 (fifo_rd is held low while clear is high). Reads in flight at reset are discarded; their data is ignored.
- fill: registered lane count, 0..RATIO. inflight: reads issued but not yet captured (RD_LAT-deep shift pipe). A read is counted as inflight up to and including its capture cycle.
- out_free = !m_valid || m_ready.
- xfer = (fill==RATIO) && out_free && !flushing.
- fifo_rd = !clear && !fifo_rempty && !flushing && ((fill+inflight < RATIO) || xfer). This never over-issues, because fill==RATIO implies inflight==0.
- Capture: when the pipe tail is set, lane[fill] <= fifo_q and fill <= fill+1.
- On xfer:
  - m_data <= lanes, m_keep <= all ones, m_last <= 0, m_valid <= 1, fill <= 0.
  - No capture can coincide with xfer.
- m_valid falls on m_ready when no new word is loaded in the same cycle. m_data, m_keep and m_last hold stable while m_valid && !m_ready.
- Throughput with a continuously non-empty FIFO and m_ready=1: one word per RATIO+RD_LAT cycles. First m_valid appears RATIO+RD_LAT+1 cycles after the first fifo_rd.
- Flush:
  - A flush pulse with flushing=0 sets flushing=1. This blocks new reads and suppresses normal xfer.
  - A flush pulse while flushing=1 is ignored.
  - A flush in the same cycle as an xfer: the xfer completes, then flushing is set.
- Flush completion: when flushing && inflight==0 && out_free, then flushing <= 0 and:
  - if fill>0: m_data <= lanes with lanes >= fill zeroed, m_keep <= (1<<fill)-1, m_last <= 1, m_valid <= 1, fill <= 0.
  - if fill==0: no output is produced.
  - A full word (fill==RATIO) pending at completion is emitted with m_keep all ones and m_last=1.
- fifo_rempty is sampled only for issue. An empty FIFO simply stalls, with no timeout.
- Width rule: fill and inflight counters are $clog2(RATIO+1) bits wide. fill+inflight is compared at one extra bit so it cannot wrap.

Test Plan:
1. Reset mid-operation: assert clear with fill=2 and 2 reads inflight -> next cycle m_valid=0, fill=0; late fifo_q data is not captured. First word after release equals the first four post-reset FIFO words.
2. Streaming: DATA_WD=8, RATIO=4, RD_LAT=2, FIFO preloaded 0x01..0x08, m_ready=1.
   - fifo_rd high cycles 0-3; m_valid in cycle 7 with m_data=0x04030201, m_keep=4'hF, m_last=0.
   - Second word 0x08070605 in cycle 13.
3. Backpressure: m_ready=0 for 10 cycles with 12 words queued -> exactly 8 reads are issued; m_data stays 0x04030201. Releasing m_ready delivers 0x08070605 with no loss or duplication.
4. Partial flush: 3 words 0xAA,0xBB,0xCC then FIFO empty, then flush -> word 0x00CCBBAA, m_keep=4'b0111, m_last=1. A second flush with fill=0 produces no output.
5. Flush with reads inflight: pulse flush on the cycle of the 2nd fifo_rd -> no further reads; the output after both captures is m_keep=4'b0011, m_last=1. Reads resume the cycle after completion.
6. RD_LAT=1, RATIO=2, continuous data -> one word every 3 cycles; first m_valid 4 cycles after the first fifo_rd.

Source files
------------

// File: rtl/maxhpc_fifo_pack.sv
// Width upsizer behind a non-showahead FIFO: issues reads, packs RATIO lanes per
// output word, and supports flush of a partial word with keep mask and last marker.
module maxhpc_fifo_pack #(
  parameter int DATA_WD = 8,
  parameter int RATIO   = 4,
  parameter int RD_LAT  = 2
) (
  input  logic                     clock,
  input  logic                     clear,
  output logic                     fifo_rd,
  input  logic [DATA_WD-1:0]       fifo_q,
  input  logic                     fifo_rempty,
  input  logic                     flush,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WD*RATIO-1:0] m_data,
  output logic [RATIO-1:0]         m_keep,
  output logic                     m_last
);

  localparam int CW = $clog2(RATIO + 1);
  localparam int IW = $clog2(RATIO);

  logic [CW-1:0]            fill;
  logic [CW-1:0]            inflight;
  logic [RD_LAT-1:0]        pipe;
  logic [RD_LAT:0]          pipe_ext;
  logic                     flushing;
  logic                     out_free;
  logic                     xfer;
  logic                     room;
  logic                     capture;
  logic                     finish;
  logic [DATA_WD-1:0]       lanes [RATIO];
  logic [DATA_WD*RATIO-1:0] packed_full;
  logic [DATA_WD*RATIO-1:0] packed_part;
  logic [RATIO-1:0]         part_keep;

  // The top bit of the extended pipe is the read whose data is on fifo_q now.
  assign pipe_ext = {pipe, fifo_rd};
  assign capture  = pipe_ext[RD_LAT];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(pipe[i]);
    end
  end

  assign out_free = !m_valid || m_ready;
  assign xfer     = (fill == CW'(RATIO)) && out_free && !flushing;
  assign room     = ({1'b0, fill} + {1'b0, inflight}) < (CW + 1)'(RATIO);
  assign fifo_rd  = !clear && !fifo_rempty && !flushing && (room || xfer);
  assign finish   = flushing && (inflight == '0) && out_free;

  // Partial words zero the lanes that were never written in this word.
  always_comb begin
    packed_full = '0;
    packed_part = '0;
    part_keep   = '0;
    for (int i = 0; i < RATIO; i++) begin
      part_keep[i] = CW'(i) < fill;
      packed_full[i*DATA_WD +: DATA_WD] = lanes[i];
      packed_part[i*DATA_WD +: DATA_WD] = part_keep[i] ? lanes[i] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      fill     <= '0;
      pipe     <= '0;
      flushing <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_keep   <= '0;
      m_last   <= 1'b0;
    end else begin
      pipe <= pipe_ext[RD_LAT-1:0];
      if (capture) begin
        lanes[fill[IW-1:0]] <= fifo_q;
        fill <= fill + CW'(1);
      end
      if (xfer) begin
        m_data  <= packed_full;
        m_keep  <= '1;
        m_last  <= 1'b0;
        m_valid <= 1'b1;
        fill    <= '0;
      end else if (finish && (fill != '0)) begin
        m_data  <= packed_part;
        m_keep  <= part_keep;
        m_last  <= 1'b1;
        m_valid <= 1'b1;
        fill    <= '0;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      // A flush arriving while one is already pending is dropped.
      if (finish) begin
        flushing <= 1'b0;
      end else if (flush && !flushing) begin
        flushing <= 1'b1;
      end
    end
  end

endmodule
